// File: rtl/branch_predictor.sv
// branch_predictor: direct-mapped branch target buffer with 2-bit saturating
// direction counters. It predicts the next fetch PC combinationally from
// if_pc, and it is trained by conditional branches resolved in MEM.
// Optional build macro BP_UPDATE_BYPASS_EN: a lookup that hits the index being
// written this cycle sees the post-update entry. Without the macro, the lookup
// sees the pre-update state.
module branch_predictor #(
  parameter int ENTRIES = 16
) (
  input  logic        CLK,
  input  logic        nRST,
  input  logic [31:0] if_pc,
  output logic        pred_taken,
  output logic [31:0] pred_target,
  input  logic        upd_en,
  input  logic [31:0] upd_pc,
  input  logic        upd_taken,
  input  logic [31:0] upd_target
);

  localparam int IDX  = $clog2(ENTRIES);
  localparam int TAGW = 30 - IDX;

  // Per-entry state. valid and ctr have a defined reset value.
  // tag and target are qualified by valid, so they carry no reset.
  logic [ENTRIES-1:0] valid_q;
  logic [1:0]         ctr_q    [ENTRIES];
  logic [TAGW-1:0]    tag_q    [ENTRIES];
  logic [31:0]        target_q [ENTRIES];

  logic [IDX-1:0]  l_idx;
  logic [IDX-1:0]  u_idx;
  logic [TAGW-1:0] l_tag;
  logic [TAGW-1:0] u_tag;

  // Address bits [1:0] play no part in indexing or tagging.
  logic unused_pc_bits;
  assign unused_pc_bits = ^{if_pc[1:0], upd_pc[1:0]};

  assign l_idx = if_pc[IDX+1:2];
  assign u_idx = upd_pc[IDX+1:2];
  assign l_tag = if_pc[31:IDX+2];
  assign u_tag = upd_pc[31:IDX+2];

  logic        u_hit;
  logic        upd_wr;
  logic [1:0]  upd_ctr_d;
  logic [31:0] upd_target_d;

  assign u_hit  = valid_q[u_idx] && (tag_q[u_idx] == u_tag);
  // A not-taken branch that misses is never allocated, so nothing is written.
  assign upd_wr = upd_en && (u_hit || upd_taken);

  // Next value of the entry being trained: saturating counter, and the new
  // target captured only on taken outcomes.
  always_comb begin
    upd_ctr_d    = 2'b10;
    upd_target_d = target_q[u_idx];
    if (upd_taken) begin
      upd_target_d = upd_target;
    end
    if (u_hit) begin
      if (upd_taken) begin
        upd_ctr_d = (ctr_q[u_idx] == 2'b11) ? 2'b11 : ctr_q[u_idx] + 2'b01;
      end else begin
        upd_ctr_d = (ctr_q[u_idx] == 2'b00) ? 2'b00 : ctr_q[u_idx] - 2'b01;
      end
    end
  end

  // valid/ctr: cleared to invalid/weak-NT on reset, written on training.
  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      valid_q <= '0;
      for (int i = 0; i < ENTRIES; i++) begin
        ctr_q[i] <= 2'b01;
      end
    end else if (upd_wr) begin
      valid_q[u_idx] <= 1'b1;
      ctr_q[u_idx]   <= upd_ctr_d;
    end
  end

  // tag/target payload: meaningless while the entry is invalid.
  always_ff @(posedge CLK) begin
    if (upd_wr) begin
      tag_q[u_idx]    <= u_tag;
      target_q[u_idx] <= upd_target_d;
    end
  end

  logic            lk_valid;
  logic [TAGW-1:0] lk_tag;
  logic [31:0]     lk_target;
  logic [1:0]      lk_ctr;
  logic            lk_hit;

  // Select the entry seen by fetch, optionally forwarding this cycle's write.
  always_comb begin
    lk_valid  = valid_q[l_idx];
    lk_tag    = tag_q[l_idx];
    lk_target = target_q[l_idx];
    lk_ctr    = ctr_q[l_idx];
`ifdef BP_UPDATE_BYPASS_EN
    // Reset gates the forward so outputs drop to no-hit immediately.
    if (nRST && upd_wr && (u_idx == l_idx)) begin
      lk_valid  = 1'b1;
      lk_tag    = u_tag;
      lk_target = upd_target_d;
      lk_ctr    = upd_ctr_d;
    end
`endif
  end

  assign lk_hit      = lk_valid && (lk_tag == l_tag);
  assign pred_taken  = lk_hit && lk_ctr[1];
  assign pred_target = pred_taken ? lk_target : (if_pc + 32'd4);

endmodule
